// File: rtl/fixed_point_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_multiplier_seq
// Description : Sequential signed fixed-point (Q(WIDTH-FRAC).FRAC) radix-2
//               shift-add multiplier with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_multiplier_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] c_pos_lim = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [2*WIDTH-1:0] c_neg_lim = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_sign;

  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic [2*WIDTH-1:0]   w_mag;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ovf;

  // Unsigned magnitude: the most negative value maps onto 2^(WIDTH-1).
  assign w_abs1 = input1[WIDTH-1] ? (~input1 + 1'b1) : input1;
  assign w_abs2 = input2[WIDTH-1] ? (~input2 + 1'b1) : input2;

  // Truncating the magnitude before applying the sign rounds toward zero.
  assign w_mag  = r_acc >> FRAC;
  assign w_res  = r_sign ? (~w_mag[WIDTH-1:0] + 1'b1) : w_mag[WIDTH-1:0];
  assign w_ovf  = r_sign ? (w_mag > c_neg_lim) : (w_mag > c_pos_lim);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RUN;
      S_RUN:    if (r_cnt == c_last_iter) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs1};
            r_mplier <= w_abs2;
            r_sign   <= input1[WIDTH-1] ^ input2[WIDTH-1];
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_cnt_w'(1);
        end
        S_FINISH: begin
          out      <= w_res;
          overflow <= w_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_point_multiplier_seq
// Description : Self-checking bench: vector table, handshake/reset sequences,
//               and random operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_point_multiplier_seq;

  localparam int WIDTH = 16;
  localparam int FRAC  = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] input1 = '0;
  logic [WIDTH-1:0] input2 = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  fixed_point_multiplier_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .input1(input1), .input2(input2),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: real-valued product magnitude truncated toward zero, then signed.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] o, output logic ov);
    longint pa, pb, mag, res;
    bit sgn;
    pa  = longint'($signed(a));
    pb  = longint'($signed(b));
    sgn = a[15] ^ b[15];
    mag = ((pa < 0) ? -pa : pa) * ((pb < 0) ? -pb : pb);
    mag = mag / (longint'(1) << FRAC);
    res = sgn ? -mag : mag;
    o   = res[15:0];
    ov  = sgn ? (mag > 32768) : (mag > 32767);
  endtask

  task automatic start_pulse(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    input1 = 16'($urandom);
    input2 = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic eov);
    int lat, bc;
    start_pulse(a, b);
    wait_done(lat, bc);
    chk({name, " latency"}, lat, 17);
    chk({name, " busy_cycles"}, bc, 17);
    chk({name, " out"}, {16'h0, out}, {16'h0, eo});
    chk({name, " overflow"}, {31'h0, overflow}, {31'h0, eov});
  endtask

  initial begin
    int lat, bc, seen;
    logic [15:0] ra, rb, eo;
    logic eov;

    vecs[0] = '{16'h00C0, 16'h0120, 16'h01B0, 1'b0};
    vecs[1] = '{16'hFF40, 16'h0120, 16'hFE50, 1'b0};
    vecs[2] = '{16'h0001, 16'h0001, 16'h0000, 1'b0};
    vecs[3] = '{16'h6400, 16'h0100, 16'hC800, 1'b1};
    vecs[4] = '{16'h3200, 16'h0100, 16'h6400, 1'b0};
    vecs[5] = '{16'h8000, 16'h0080, 16'h8000, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[7] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[8] = '{16'h0000, 16'h8000, 16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'h0, busy}, 0);
    chk("reset done", {31'h0, done}, 0);
    chk("reset out", {16'h0, out}, 0);
    chk("reset overflow", {31'h0, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle no busy", {31'h0, busy}, 0);
    chk("idle no done", {31'h0, done}, 0);

    // Back-to-back: each op is launched during the previous op's done cycle.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].ov);

    @(posedge clk);
    #1;
    chk("done one-cycle pulse", {31'h0, done}, 0);
    chk("out holds", {16'h0, out}, 16'h0000);

    // Start while busy is ignored; the first operands' result is returned.
    start_pulse(16'h00C0, 16'h0120);
    repeat (4) @(posedge clk);
    start_pulse(16'h6400, 16'h0100);
    wait_done(lat, bc);
    chk("busy-start latency", lat, 12);
    chk("busy-start out", {16'h0, out}, 16'h01B0);
    chk("busy-start overflow", {31'h0, overflow}, 0);
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("busy-start not queued", seen, 0);

    // Reset during iteration 8 discards the operation.
    start_pulse(16'h3200, 16'h0100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset busy", {31'h0, busy}, 0);
    chk("midreset done", {31'h0, done}, 0);
    chk("midreset out", {16'h0, out}, 0);
    chk("midreset overflow", {31'h0, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midreset no done", seen, 0);
    run_op("after-reset", 16'hFF40, 16'h0120, 16'hFE50, 1'b0);

    // Randomized operands, half of them small enough to stay in range.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 0) begin
        ra = {{4{ra[11]}}, ra[11:0]};
        rb = {{6{rb[9]}}, rb[9:0]};
      end
      model(ra, rb, eo, eov);
      run_op($sformatf("rand%0d %h*%h", i, ra, rb), ra, rb, eo, eov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
